// File: rtl/link_token_responder_pkg.sv
// ============================================================================
// Module : link_ring_pkg
// Brief  : Shared beat type, responder state encoding and link width.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package link_ring_pkg;

    localparam int LINK_W = 32;

    typedef struct packed {
        logic [LINK_W-1:0] token;
        logic [LINK_W-1:0] clk_cnt;
        logic [LINK_W-1:0] id;
    } link_beat_t;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_HOLD = 2'd1,
        RESP_SEND = 2'd2
    } resp_state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

endpackage

`default_nettype wire

// File: rtl/link_token_responder_if.sv
// ============================================================================
// Module : link_token_responder_if
// Brief  : One link beat (valid + token/timestamp/id), no backpressure.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface link_token_responder_if;
    import link_ring_pkg::*;

    logic              wen;
    logic [LINK_W-1:0] token;
    logic [LINK_W-1:0] clk_cnt;
    logic [LINK_W-1:0] id;

    modport master (output wen, token, clk_cnt, id);
    modport slave  (input  wen, token, clk_cnt, id);
endinterface

`default_nettype wire

// File: rtl/link_token_responder_fifo.sv
// ============================================================================
// Module : link_beat_fifo
// Brief  : DEPTH-entry beat FIFO; a push into a full FIFO succeeds with a pop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module link_beat_fifo
    import link_ring_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    input  wire logic       i_push,
    input  link_beat_t      i_data,
    input  wire logic       i_pop,
    output link_beat_t      o_data,
    output logic            o_full,
    output logic            o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    link_beat_t    mem_q [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    // DEPTH is a power of two, so the count MSB alone flags full.
    assign o_full    = count_q[AW];
    assign o_empty   = (count_q == '0);
    assign o_data    = mem_q[rd_ptr_q];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (w_do_pop && !w_do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/link_token_responder.sv
// ============================================================================
// Module : link_token_responder
// Brief  : Ring tail: checks/buffers incoming beats, returns token+1 responses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module link_token_responder
    import link_ring_pkg::*;
#(
    parameter logic [LINK_W-1:0] MY_ID        = 32'd255,
    parameter logic [LINK_W-1:0] EXPECT_ID    = 32'd0,
    parameter logic [LINK_W-1:0] TOKEN_STEP   = 32'd1,
    parameter int                DEPTH        = 4,
    parameter int                RESP_DELAY   = 0,
    parameter int                BENCH_PERIOD = 16
) (
    input  wire logic               i_clk,
    input  wire logic               i_rst,
    link_token_responder_if.slave   rx_if,
    link_token_responder_if.master  tx_if,
    output logic                    o_seq_err,
    output logic                    o_id_err,
    output logic                    o_ovf,
    output logic [15:0]             o_err_cnt,
    output logic [LINK_W-1:0]       o_rx_cnt,
    output logic                    o_benchmark_event
);

    localparam logic [7:0]        C_DLY       = 8'(RESP_DELAY);
    localparam logic [LINK_W-1:0] C_BENCH_DIV = (BENCH_PERIOD == 0) ? 32'd1 : 32'(BENCH_PERIOD);

    logic [1:0]        state_q, state_d;
    logic [7:0]        dly_q, dly_d;
    logic [LINK_W-1:0] hold_tok_q, hold_tok_d;
    logic [LINK_W-1:0] cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [LINK_W-1:0] tok_q, tok_d;
    logic [LINK_W-1:0] ts_q, ts_d;
    logic [LINK_W-1:0] id_q, id_d;
    logic              first_q, first_d;
    logic [LINK_W-1:0] prev_token_q, prev_token_d;
    logic [LINK_W-1:0] prev_clk_q, prev_clk_d;
    logic              seq_err_q, seq_err_d;
    logic              id_err_q, id_err_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [LINK_W-1:0] rx_cnt_q, rx_cnt_d;
    logic              bench_q, bench_d;

    link_beat_t  w_in_beat;
    link_beat_t  w_fifo_rd;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_accept;
    logic        w_drop;
    logic        w_id_bad;
    logic        w_seq_bad;
    logic [1:0]  w_n_err;
    logic [16:0] w_err_sum;
    logic        w_unused_fields;

    assign w_in_beat = '{token: rx_if.token, clk_cnt: rx_if.clk_cnt, id: rx_if.id};

    // Only the token travels to the response; the rest is kept for ring-wide beat format.
    assign w_unused_fields = ^{w_fifo_rd.clk_cnt, w_fifo_rd.id};

    link_beat_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (rx_if.wen),
        .i_data  (w_in_beat),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rd),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop     = ((state_q == ST_IDLE) || (state_q == ST_SEND)) && !w_empty;
    assign w_accept  = rx_if.wen && (!w_full || w_pop);
    assign w_drop    = rx_if.wen && !w_accept;
    assign w_id_bad  = rx_if.wen && (rx_if.id != EXPECT_ID);
    assign w_seq_bad = rx_if.wen && !first_q &&
                       ((rx_if.token != prev_token_q + TOKEN_STEP) ||
                        (rx_if.clk_cnt <= prev_clk_q));
    assign w_n_err   = {1'b0, w_id_bad} + {1'b0, w_seq_bad} + {1'b0, w_drop};
    assign w_err_sum = {1'b0, err_cnt_q} + {15'd0, w_n_err};

    always_comb begin
        first_d      = first_q;
        prev_token_d = prev_token_q;
        prev_clk_d   = prev_clk_q;
        if (rx_if.wen) begin
            first_d      = 1'b0;
            prev_token_d = rx_if.token;
            prev_clk_d   = rx_if.clk_cnt;
        end
        seq_err_d = seq_err_q | w_seq_bad;
        id_err_d  = id_err_q  | w_id_bad;
        ovf_d     = ovf_q     | w_drop;
        err_cnt_d = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        rx_cnt_d  = rx_cnt_q + (w_accept ? 32'd1 : 32'd0);
        bench_d   = (BENCH_PERIOD != 0) && w_accept && ((rx_cnt_d % C_BENCH_DIV) == 32'd0);
    end

    always_comb begin
        cnt_d      = cnt_q + 32'd1;
        state_d    = state_q;
        dly_d      = dly_q;
        hold_tok_d = hold_tok_q;
        wen_d      = 1'b0;
        tok_d      = tok_q;
        ts_d       = ts_q;
        id_d       = id_q;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    state_d    = ST_HOLD;
                    dly_d      = C_DLY;
                    hold_tok_d = w_fifo_rd.token;
                end
            end
            ST_HOLD: begin
                if (dly_q == 8'd0) begin
                    // Response fields register together with o_wen so they appear in the SEND cycle.
                    state_d = ST_SEND;
                    wen_d   = 1'b1;
                    tok_d   = hold_tok_q + 32'd1;
                    ts_d    = cnt_d;
                    id_d    = MY_ID;
                end else begin
                    dly_d = dly_q - 8'd1;
                end
            end
            ST_SEND: begin
                if (!w_empty) begin
                    state_d    = ST_HOLD;
                    dly_d      = C_DLY;
                    hold_tok_d = w_fifo_rd.token;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            dly_q        <= '0;
            hold_tok_q   <= '0;
            cnt_q        <= '0;
            wen_q        <= 1'b0;
            tok_q        <= '0;
            ts_q         <= '0;
            id_q         <= '0;
            first_q      <= 1'b1;
            prev_token_q <= '0;
            prev_clk_q   <= '0;
            seq_err_q    <= 1'b0;
            id_err_q     <= 1'b0;
            ovf_q        <= 1'b0;
            err_cnt_q    <= '0;
            rx_cnt_q     <= '0;
            bench_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            hold_tok_q   <= hold_tok_d;
            cnt_q        <= cnt_d;
            wen_q        <= wen_d;
            tok_q        <= tok_d;
            ts_q         <= ts_d;
            id_q         <= id_d;
            first_q      <= first_d;
            prev_token_q <= prev_token_d;
            prev_clk_q   <= prev_clk_d;
            seq_err_q    <= seq_err_d;
            id_err_q     <= id_err_d;
            ovf_q        <= ovf_d;
            err_cnt_q    <= err_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            bench_q      <= bench_d;
        end
    end

    assign tx_if.wen         = wen_q;
    assign tx_if.token       = tok_q;
    assign tx_if.clk_cnt     = ts_q;
    assign tx_if.id          = id_q;
    assign o_seq_err         = seq_err_q;
    assign o_id_err          = id_err_q;
    assign o_ovf             = ovf_q;
    assign o_err_cnt         = err_cnt_q;
    assign o_rx_cnt          = rx_cnt_q;
    assign o_benchmark_event = bench_q;

endmodule

`default_nettype wire

// File: tb/tb_link_token_responder.sv
// ============================================================================
// Module : tb_link_token_responder
// Brief  : Two responders (delay 0 / period 4, delay 8 / period 16) on one link vs a timing model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_link_token_responder;
    import link_ring_pkg::*;

    localparam logic [31:0] MY_ID     = 32'd255;
    localparam logic [31:0] EXPECT_ID = 32'd0;
    localparam logic [31:0] STEP      = 32'd1;
    localparam int          DEPTH     = 4;
    localparam int          MAXB      = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    link_token_responder_if rx_if ();
    link_token_responder_if tx0 ();
    link_token_responder_if tx1 ();

    logic        o_seq   [2];
    logic        o_idr   [2];
    logic        o_ovf   [2];
    logic        o_bench [2];
    logic [15:0] o_err   [2];
    logic [31:0] o_rx    [2];
    logic        o_wen   [2];
    logic [31:0] o_tok   [2];
    logic [31:0] o_ts    [2];
    logic [31:0] o_id    [2];

    assign o_wen[0] = tx0.wen;  assign o_tok[0] = tx0.token;
    assign o_ts[0]  = tx0.clk_cnt; assign o_id[0] = tx0.id;
    assign o_wen[1] = tx1.wen;  assign o_tok[1] = tx1.token;
    assign o_ts[1]  = tx1.clk_cnt; assign o_id[1] = tx1.id;

    link_token_responder #(
        .MY_ID(MY_ID), .EXPECT_ID(EXPECT_ID), .TOKEN_STEP(STEP),
        .DEPTH(DEPTH), .RESP_DELAY(0), .BENCH_PERIOD(4)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .rx_if(rx_if), .tx_if(tx0),
        .o_seq_err(o_seq[0]), .o_id_err(o_idr[0]), .o_ovf(o_ovf[0]),
        .o_err_cnt(o_err[0]), .o_rx_cnt(o_rx[0]), .o_benchmark_event(o_bench[0])
    );

    link_token_responder #(
        .MY_ID(MY_ID), .EXPECT_ID(EXPECT_ID), .TOKEN_STEP(STEP),
        .DEPTH(DEPTH), .RESP_DELAY(8), .BENCH_PERIOD(16)
    ) dut1 (
        .i_clk(clk), .i_rst(rst), .rx_if(rx_if), .tx_if(tx1),
        .o_seq_err(o_seq[1]), .o_id_err(o_idr[1]), .o_ovf(o_ovf[1]),
        .o_err_cnt(o_err[1]), .o_rx_cnt(o_rx[1]), .o_benchmark_event(o_bench[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int dly_of(input int k);
        return (k == 0) ? 0 : 8;
    endfunction

    function automatic int per_of(input int k);
        return (k == 0) ? 4 : 16;
    endfunction

    // Model: each accepted beat gets its send edge s and pop edge s-1-D up front.
    int          ecount;
    int          acc_s   [2][MAXB];
    int          acc_p   [2][MAXB];
    logic [31:0] acc_tok [2][MAXB];
    int          n_acc [2];
    int          nxt   [2];
    int          last_s[2];
    bit          first_m [2];
    logic [31:0] prev_tok[2];
    logic [31:0] prev_ts [2];
    bit          m_seq[2], m_id[2], m_ovf[2], m_bench[2];
    int          m_err[2];
    logic [31:0] m_rx[2], m_tok[2], m_ts[2], m_idout[2];

    task automatic model_reset();
        ecount = 0;
        for (int k = 0; k < 2; k++) begin
            n_acc[k] = 0; nxt[k] = 0; last_s[k] = -1000;
            first_m[k] = 1'b1; prev_tok[k] = '0; prev_ts[k] = '0;
            m_seq[k] = 0; m_id[k] = 0; m_ovf[k] = 0; m_bench[k] = 0;
            m_err[k] = 0; m_rx[k] = '0; m_tok[k] = '0; m_ts[k] = '0; m_idout[k] = '0;
        end
    endtask

    task automatic model_edge(input int k, input int e);
        bit idb, sqb, drop, popnow;
        int occ, nerr, d, s;
        m_bench[k] = 0;
        if (rx_if.wen === 1'b1) begin
            d    = dly_of(k);
            idb  = (rx_if.id != EXPECT_ID);
            sqb  = !first_m[k] && ((rx_if.token != prev_tok[k] + STEP) || (rx_if.clk_cnt <= prev_ts[k]));
            occ  = 0;
            popnow = 0;
            for (int j = 0; j < n_acc[k]; j++) begin
                if (acc_p[k][j] >= e) occ++;
                if (acc_p[k][j] == e) popnow = 1;
            end
            drop = (occ == DEPTH) && !popnow;
            nerr = int'(idb) + int'(sqb) + int'(drop);
            m_err[k] = (m_err[k] + nerr > 65535) ? 65535 : m_err[k] + nerr;
            if (idb)  m_id[k]  = 1;
            if (sqb)  m_seq[k] = 1;
            if (drop) m_ovf[k] = 1;
            if (!drop && n_acc[k] < MAXB) begin
                s = (e + 2 + d > last_s[k] + d + 2) ? e + 2 + d : last_s[k] + d + 2;
                acc_s[k][n_acc[k]]   = s;
                acc_p[k][n_acc[k]]   = s - 1 - d;
                acc_tok[k][n_acc[k]] = rx_if.token + 32'd1;
                n_acc[k]++;
                last_s[k] = s;
                m_rx[k]   = m_rx[k] + 32'd1;
                if ((m_rx[k] % 32'(per_of(k))) == 32'd0) m_bench[k] = 1;
            end
            prev_tok[k] = rx_if.token;
            prev_ts[k]  = rx_if.clk_cnt;
            first_m[k]  = 0;
        end
    endtask

    task automatic check_outputs(input int k, input int e);
        bit ew;
        ew = 0;
        if (nxt[k] < n_acc[k] && acc_s[k][nxt[k]] == e) begin
            ew         = 1;
            m_tok[k]   = acc_tok[k][nxt[k]];
            m_ts[k]    = 32'(e);
            m_idout[k] = MY_ID;
            nxt[k]++;
        end
        check($sformatf("d%0d.wen", k),     {31'd0, o_wen[k]},   {31'd0, ew});
        check($sformatf("d%0d.token", k),   o_tok[k],            m_tok[k]);
        check($sformatf("d%0d.clk_cnt", k), o_ts[k],             m_ts[k]);
        check($sformatf("d%0d.id", k),      o_id[k],             m_idout[k]);
        check($sformatf("d%0d.seq_err", k), {31'd0, o_seq[k]},   {31'd0, m_seq[k]});
        check($sformatf("d%0d.id_err", k),  {31'd0, o_idr[k]},   {31'd0, m_id[k]});
        check($sformatf("d%0d.ovf", k),     {31'd0, o_ovf[k]},   {31'd0, m_ovf[k]});
        check($sformatf("d%0d.err_cnt", k), {16'd0, o_err[k]},   32'(m_err[k]));
        check($sformatf("d%0d.rx_cnt", k),  o_rx[k],             m_rx[k]);
        check($sformatf("d%0d.bench", k),   {31'd0, o_bench[k]}, {31'd0, m_bench[k]});
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            ecount++;
            model_edge(0, ecount);
            model_edge(1, ecount);
        end
        #1;
        check_outputs(0, ecount);
        check_outputs(1, ecount);
    end

    logic [31:0] g_tok;
    logic [31:0] g_ts;

    task automatic beat(input logic [31:0] tok, input logic [31:0] ts, input logic [31:0] id);
        @(negedge clk);
        rx_if.wen     = 1'b1;
        rx_if.token   = tok;
        rx_if.clk_cnt = ts;
        rx_if.id      = id;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_if.wen = 1'b0;
        end
    endtask

    task automatic good_beats(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            g_tok = g_tok + STEP;
            g_ts  = g_ts + 32'($urandom_range(1, 3));
            beat(g_tok, g_ts, EXPECT_ID);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_if.wen = 1'b0;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d.rst_wen", k),   {31'd0, o_wen[k]}, 32'd0);
            check($sformatf("d%0d.rst_token", k), o_tok[k],          32'd0);
            check($sformatf("d%0d.rst_err", k),   {16'd0, o_err[k]}, 32'd0);
            check($sformatf("d%0d.rst_rx", k),    o_rx[k],           32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        g_ts = 32'd1000;
    endtask

    initial begin
        int r;
        rx_if.wen = 1'b0; rx_if.token = '0; rx_if.clk_cnt = '0; rx_if.id = '0;
        g_tok = '0; g_ts = 32'd1000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // single beat, latency and token+1
        beat(32'd5, 32'd100, EXPECT_ID);
        idle(20);

        // token order violation
        do_reset();
        beat(32'd1, 32'd200, EXPECT_ID);
        beat(32'd2, 32'd201, EXPECT_ID);
        beat(32'd4, 32'd202, EXPECT_ID);
        idle(40);

        // six back-to-back beats overflow the slow responder
        do_reset();
        g_tok = 32'd9;
        good_beats(6, 0);
        idle(70);

        // token wrap
        do_reset();
        beat(32'hFFFF_FFFF, 32'd300, EXPECT_ID);
        beat(32'h0000_0000, 32'd301, EXPECT_ID);
        idle(30);

        // benchmark pulses
        do_reset();
        g_tok = 32'd100;
        good_beats(8, 1);
        idle(90);

        // reset while holding with two queued beats, next beat is a first beat
        do_reset();
        g_tok = 32'd40;
        good_beats(3, 0);
        idle(2);
        do_reset();
        beat(32'd77, 32'd5, EXPECT_ID);
        idle(30);

        // randomized traffic with injected errors and bursts
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            g_tok = $urandom;
            for (int c = 0; c < 150; c++) begin
                r = int'($urandom_range(0, 99));
                if (r < 50) begin
                    g_tok = g_tok + STEP;
                    g_ts  = g_ts + 32'($urandom_range(1, 4));
                    if ($urandom_range(0, 19) == 0) g_tok = g_tok + 32'd1;
                    if ($urandom_range(0, 19) == 0) g_ts = g_ts - 32'd5;
                    beat(g_tok, g_ts, ($urandom_range(0, 19) == 0) ? 32'($urandom_range(1, 9)) : EXPECT_ID);
                end else begin
                    idle(1);
                end
            end
            idle(100);
        end

        idle(5);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
